// File: rtl/nz_stream_pkg.sv
// Shared sizing and state encoding for the nonzero-index streamer.
// The other nz_* files import this package.
package nz_stream_pkg;

   localparam int NUM_ELEM = 128;
   localparam int PSUM_W   = 8;
   localparam int IDX_W    = 7;
   localparam int LANES    = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_e;

endpackage

// File: rtl/nz_lane_select.sv
// One output lane: finds the element whose inclusive prefix sum hits the target.
// On an inconsistent psum the lowest matching index wins.
module nz_lane_select
   import nz_stream_pkg::*;
(
   input  logic [NUM_ELEM-1:0]        mask,
   input  logic [NUM_ELEM*PSUM_W-1:0] psum,
   input  logic [PSUM_W:0]            target,
   output logic [IDX_W-1:0]           idx,
   output logic                       hit
);

   always_comb begin
      idx = '0;
      hit = 1'b0;
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = NUM_ELEM - 1; i >= 0; i--) begin
         if (mask[i] && ({1'b0, psum[i*PSUM_W +: PSUM_W]} == target)) begin
            idx = IDX_W'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nz_index_streamer.sv
// Streams set-bit positions of a sparsity mask as LANES indices per beat.
// Define NZ_STREAM_OVERLAP_EN to accept a new vector on the last-beat edge.
module nz_index_streamer
   import nz_stream_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_ELEM-1:0]        in_mask,
   input  logic [NUM_ELEM*PSUM_W-1:0] in_psum,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LANES*IDX_W-1:0]     out_idx,
   output logic [LANES-1:0]           out_lane_valid,
   output logic                       out_last,
   output logic                       busy
);

   state_e                    state_q, state_d;
   logic [NUM_ELEM-1:0]        mask_q;
   logic [NUM_ELEM*PSUM_W-1:0] psum_q;
   logic [PSUM_W-1:0]          base_q, base_d;
   logic [PSUM_W-1:0]          total_q;
   logic [PSUM_W:0]            base_x, total_x;
   logic                       emit, fire, accept;
   logic [LANES-1:0]           hit;
   logic [LANES*IDX_W-1:0]     sel_idx;

   assign emit    = (state_q == ST_EMIT);
   assign base_x  = {1'b0, base_q};
   assign total_x = {1'b0, total_q};

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [PSUM_W:0] target;
      assign target = base_x + (PSUM_W+1)'(k + 1);

      nz_lane_select u_sel (
         .mask   (mask_q),
         .psum   (psum_q),
         .target (target),
         .idx    (sel_idx[k*IDX_W +: IDX_W]),
         .hit    (hit[k])
      );

      assign out_lane_valid[k] = emit && ((base_x + (PSUM_W+1)'(k)) < total_x);
      assign out_idx[k*IDX_W +: IDX_W] =
         (out_lane_valid[k] && hit[k]) ? sel_idx[k*IDX_W +: IDX_W] : '0;
   end

   assign out_valid = emit;
   assign busy      = emit;
   assign out_last  = emit && ((base_x + (PSUM_W+1)'(LANES)) >= total_x);
   assign fire      = out_valid && out_ready;

`ifdef NZ_STREAM_OVERLAP_EN
   assign in_ready = !emit || (fire && out_last);
`else
   assign in_ready = !emit;
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_EMIT;
         ST_EMIT: begin
            if (fire) begin
               if (out_last) state_d = accept ? ST_EMIT : ST_IDLE;
               else          base_d  = base_q + PSUM_W'(LANES);
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) base_d = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         psum_q  <= '0;
         base_q  <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         if (accept) begin
            mask_q  <= in_mask;
            psum_q  <= in_psum;
            total_q <= in_psum[(NUM_ELEM-1)*PSUM_W +: PSUM_W];
         end
      end
   end

endmodule
